ddr_multi_buffer_loader: RTL and testbench
==========================================

// Module: ddr_multi_buffer_loader
// PURPOSE
//   Multi-burst DDR-to-on-chip-buffer loader. Next generation of the single-burst init controller.
//   Splits one load command of up to 2^LEN_WIDTH-1 beats into DDR bursts of at most BURST_MAX beats.
//   Issues each burst on a valid/ready request channel and streams the returned beats into one of BUF_COUNT buffers.
//   Sits between the top-level sequencer and the inst/bias/tail/rank (and further) buffers.
// PARAMETERS
//   DDR_ADDR_WIDTH  32   DDR byte-address width
//   BUF_ADDR_WIDTH  16   buffer word-address width
//   DATA_WIDTH      512  beat width; BYTES_PER_BEAT = DATA_WIDTH/8 (localparam)
//   LEN_WIDTH       16   width of the total-beat count
//   BURST_WIDTH     8    width of ddr_req_len
//   BURST_MAX       64   max beats per DDR burst; 1..2^BURST_WIDTH-1
//   BUF_COUNT       4    number of target buffers (one write-enable each)
//   BUF_ID_WIDTH    3    width of buffer_id
// PORTS
//   clk            in   1               clock, all logic on rising edge
//   n_reset        in   1               asynchronous active-low reset
//   start          in   1               one-cycle command strobe
//   buffer_id      in   BUF_ID_WIDTH    target buffer index, sampled with start
//   ddr_base_addr  in   DDR_ADDR_WIDTH  first DDR byte address, sampled with start
//   buf_base_addr  in   BUF_ADDR_WIDTH  first buffer word address, sampled with start
//   total_len      in   LEN_WIDTH       total beats to load, sampled with start
//   busy           out  1               high from accepted start until done
//   done           out  1               one-cycle completion pulse
//   error          out  1               one-cycle pulse with done on a rejected command
//   ddr_req_valid  out  1               burst request valid
//   ddr_req_ready  in   1               burst request accepted
//   ddr_req_addr   out  DDR_ADDR_WIDTH  burst DDR byte address
//   ddr_req_len    out  BURST_WIDTH     burst length in beats
//   ddr_rvalid     in   1               read beat valid (no backpressure)
//   ddr_rdata      in   DATA_WIDTH      read beat data
//   buf_wr_en      out  BUF_COUNT       one-hot write enable; bit i targets buffer i
//   buf_addr       out  BUF_ADDR_WIDTH  buffer write address
//   buf_data       out  DATA_WIDTH      buffer write data
// BEHAVIOUR
//   Reset (async, n_reset=0): state IDLE; all outputs 0; all counters and latched fields cleared.
//     Reset mid-load aborts immediately; no done pulse.
//   FSM: IDLE -> REQ -> RECV -> (REQ | FIN) -> IDLE.
//   Command acceptance
//     - start is acted on only in IDLE; ignored in any other state.
//     - Inputs are latched. busy=1 from the next cycle.
//   Rejected command: buffer_id>=BUF_COUNT or total_len==0.
//     - Goes IDLE -> FIN directly. No DDR request, no writes.
//     - done=1 and error=1 in the same single cycle.
//   REQ
//     - ddr_req_valid=1; ddr_req_len = min(remaining, BURST_MAX); ddr_req_addr = current DDR address.
//     - Request fields are held stable until ddr_req_ready=1 in a valid cycle, then RECV next cycle.
//     - On acceptance: DDR address += ddr_req_len*BYTES_PER_BEAT (wraps mod 2^DDR_ADDR_WIDTH);
//       remaining -= ddr_req_len.
//   RECV
//     - Each ddr_rvalid beat is registered.
//     - Next cycle: buf_wr_en = one-hot(buffer_id), buf_data = beat, buf_addr = current buffer address.
//     - Buffer address then increments by 1, wrapping mod 2^BUF_ADDR_WIDTH.
//     - Write latency is exactly 1 cycle; back-to-back beats give back-to-back writes.
//     - On the last beat of the burst: REQ if remaining>0, else FIN.
//     - The next request may be issued while the final write of the previous burst is in flight.
//   ddr_rvalid outside RECV: ignored, no write.
//   FIN
//     - Lasts one cycle and follows the last write-enable cycle.
//     - done=1 in the cycle after FIN is entered; busy falls in the same cycle as done.
//   Idle outputs: buf_wr_en, buf_data, buf_addr and ddr_req_* are 0 whenever not writing / not requesting.
// TESTING
//   T1 buffer_id=1, total_len=5, BURST_MAX=64, ddr_req_ready=1 -> one request (len=5);
//      5 writes with buf_wr_en=4'b0010 at buf_base..+4; done 1 pulse, error=0.
//   T2 total_len=150, ddr_base=0x1000, BURST_MAX=64 -> requests len 64/64/22
//      at 0x1000/0x2000/0x3000; 150 contiguous writes.
//   T3 hold ddr_req_ready=0 for 7 cycles -> addr/len stable for all 7 cycles; exactly one request accepted.
//   T4 buffer_id=5 (BUF_COUNT=4), or total_len=0 -> done=error=1 for one cycle; no request, no writes.
//   T5 buf_base=0xFFFE, total_len=4 -> writes at 0xFFFE,0xFFFF,0x0000,0x0001.
//      A second start while busy is ignored.
//   T6 drop n_reset mid-burst -> outputs 0 asynchronously; no done.
//      A fresh start after reset completes normally.

Source files
------------

// File: rtl/ddr_multi_buffer_loader.sv
// Multi-burst DDR-to-buffer loader: splits one load command into DDR bursts of at
// most BURST_MAX beats and streams the returned beats into one of BUF_COUNT buffers.
module ddr_multi_buffer_loader #(
  parameter int DDR_ADDR_WIDTH = 32,
  parameter int BUF_ADDR_WIDTH = 16,
  parameter int DATA_WIDTH     = 512,
  parameter int LEN_WIDTH      = 16,
  parameter int BURST_WIDTH    = 8,
  parameter int BURST_MAX      = 64,
  parameter int BUF_COUNT      = 4,
  parameter int BUF_ID_WIDTH   = 3
) (
  input  logic                      clk,
  input  logic                      n_reset,
  input  logic                      start,
  input  logic [BUF_ID_WIDTH-1:0]   buffer_id,
  input  logic [DDR_ADDR_WIDTH-1:0] ddr_base_addr,
  input  logic [BUF_ADDR_WIDTH-1:0] buf_base_addr,
  input  logic [LEN_WIDTH-1:0]      total_len,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic                      ddr_req_valid,
  input  logic                      ddr_req_ready,
  output logic [DDR_ADDR_WIDTH-1:0] ddr_req_addr,
  output logic [BURST_WIDTH-1:0]    ddr_req_len,
  input  logic                      ddr_rvalid,
  input  logic [DATA_WIDTH-1:0]     ddr_rdata,
  output logic [BUF_COUNT-1:0]      buf_wr_en,
  output logic [BUF_ADDR_WIDTH-1:0] buf_addr,
  output logic [DATA_WIDTH-1:0]     buf_data
);

  localparam int BYTES_PER_BEAT = DATA_WIDTH / 8;

  // state | meaning
  // IDLE  | waiting for start
  // REQ   | burst request presented, waiting for ddr_req_ready
  // RECV  | collecting beats of the accepted burst
  // FIN   | last write in flight (or command rejected); done follows
  typedef enum logic [1:0] {IDLE, REQ, RECV, FIN} state_t;

  state_t                    state;
  logic [BUF_ID_WIDTH-1:0]   id_q;
  logic [DDR_ADDR_WIDTH-1:0] ddr_addr;
  logic [BUF_ADDR_WIDTH-1:0] wr_addr;
  logic [LEN_WIDTH-1:0]      remaining;
  logic [BURST_WIDTH-1:0]    beats_left;
  logic                      rejected;
  logic                      reject;

  function automatic logic [BURST_WIDTH-1:0] burst_of(input logic [LEN_WIDTH-1:0] r);
    if (32'(r) > 32'(BURST_MAX)) return BURST_WIDTH'(BURST_MAX);
    return BURST_WIDTH'(r);
  endfunction

  assign reject = (32'(buffer_id) >= 32'(BUF_COUNT)) || (total_len == '0);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state         <= IDLE;
      id_q          <= '0;
      ddr_addr      <= '0;
      wr_addr       <= '0;
      remaining     <= '0;
      beats_left    <= '0;
      rejected      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      ddr_req_valid <= 1'b0;
      ddr_req_addr  <= '0;
      ddr_req_len   <= '0;
      buf_wr_en     <= '0;
      buf_addr      <= '0;
      buf_data      <= '0;
    end else begin
      done      <= 1'b0;
      error     <= 1'b0;
      buf_wr_en <= '0;
      buf_addr  <= '0;
      buf_data  <= '0;
      unique case (state)
        IDLE: begin
          if (start) begin
            id_q      <= buffer_id;
            ddr_addr  <= ddr_base_addr;
            wr_addr   <= buf_base_addr;
            remaining <= total_len;
            busy      <= 1'b1;
            if (reject) begin
              rejected <= 1'b1;
              state    <= FIN;
            end else begin
              ddr_req_valid <= 1'b1;
              ddr_req_addr  <= ddr_base_addr;
              ddr_req_len   <= burst_of(total_len);
              state         <= REQ;
            end
          end
        end
        REQ: begin
          if (ddr_req_ready) begin
            ddr_req_valid <= 1'b0;
            ddr_req_addr  <= '0;
            ddr_req_len   <= '0;
            ddr_addr      <= ddr_addr + DDR_ADDR_WIDTH'(ddr_req_len) * DDR_ADDR_WIDTH'(BYTES_PER_BEAT);
            remaining     <= remaining - LEN_WIDTH'(ddr_req_len);
            beats_left    <= ddr_req_len;
            state         <= RECV;
          end
        end
        RECV: begin
          if (ddr_rvalid) begin
            buf_wr_en  <= BUF_COUNT'(1) << id_q;
            buf_addr   <= wr_addr;
            buf_data   <= ddr_rdata;
            wr_addr    <= wr_addr + BUF_ADDR_WIDTH'(1);
            beats_left <= beats_left - BURST_WIDTH'(1);
            // Next request goes out while this final write is still registered.
            if (beats_left == BURST_WIDTH'(1)) begin
              if (remaining != '0) begin
                ddr_req_valid <= 1'b1;
                ddr_req_addr  <= ddr_addr;
                ddr_req_len   <= burst_of(remaining);
                state         <= REQ;
              end else begin
                state <= FIN;
              end
            end
          end
        end
        FIN: begin
          done     <= 1'b1;
          error    <= rejected;
          busy     <= 1'b0;
          rejected <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_multi_buffer_loader.sv
// Randomized bench for ddr_multi_buffer_loader: a DDR responder, a bus monitor and a
// spec-level model of burst splitting and buffer writes.
module tb_ddr_multi_buffer_loader;
  localparam int DAW = 32, BAW = 16, DW = 512, LW = 16, BW = 8, BM = 64, BC = 4, BIW = 3;
  localparam int BPB = DW / 8;

  logic           clk = 1'b0, n_reset = 1'b0, start = 1'b0;
  logic [BIW-1:0] buffer_id = '0;
  logic [DAW-1:0] ddr_base_addr = '0;
  logic [BAW-1:0] buf_base_addr = '0;
  logic [LW-1:0]  total_len = '0;
  logic           busy, done, error, ddr_req_valid, ddr_req_ready, ddr_rvalid;
  logic [DAW-1:0] ddr_req_addr;
  logic [BW-1:0]  ddr_req_len;
  logic [DW-1:0]  ddr_rdata, buf_data;
  logic [BC-1:0]  buf_wr_en;
  logic [BAW-1:0] buf_addr;

  ddr_multi_buffer_loader dut (
    .clk(clk), .n_reset(n_reset), .start(start), .buffer_id(buffer_id),
    .ddr_base_addr(ddr_base_addr), .buf_base_addr(buf_base_addr), .total_len(total_len),
    .busy(busy), .done(done), .error(error),
    .ddr_req_valid(ddr_req_valid), .ddr_req_ready(ddr_req_ready),
    .ddr_req_addr(ddr_req_addr), .ddr_req_len(ddr_req_len),
    .ddr_rvalid(ddr_rvalid), .ddr_rdata(ddr_rdata),
    .buf_wr_en(buf_wr_en), .buf_addr(buf_addr), .buf_data(buf_data)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed traffic
  logic [BAW-1:0] wr_addr_q[$];
  logic [BC-1:0]  wr_en_q[$];
  logic [DW-1:0]  wr_data_q[$];
  int             wr_cyc_q[$];
  logic [DAW-1:0] rq_addr_q[$];
  logic [BW-1:0]  rq_len_q[$];
  int             done_cyc_q[$];
  logic           done_err_q[$];
  logic [DW-1:0]  beat_q[$];
  int             granted = 0, sent = 0, viol = 0;
  logic           pv = 1'b0;
  logic [DAW-1:0] pa = '0;
  logic [BW-1:0]  pl = '0;
  int             ready_mode = 0;
  bit             spur = 1'b0;

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] b;
    for (int i = 0; i < DW / 32; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  // Monitor: samples on the falling edge, records traffic and protocol violations.
  always @(negedge clk) begin
    if (buf_wr_en != '0) begin
      wr_addr_q.push_back(buf_addr); wr_en_q.push_back(buf_wr_en);
      wr_data_q.push_back(buf_data); wr_cyc_q.push_back(cyc);
    end
    if (ddr_req_valid && ddr_req_ready) begin
      rq_addr_q.push_back(ddr_req_addr); rq_len_q.push_back(ddr_req_len);
      granted = granted + int'(ddr_req_len);
    end
    if (done) begin done_cyc_q.push_back(cyc); done_err_q.push_back(error); end
    if (buf_wr_en == '0 && (buf_addr != '0 || buf_data != '0)) viol++;
    if (!ddr_req_valid && (ddr_req_addr != '0 || ddr_req_len != '0)) viol++;
    if ($countones(buf_wr_en) > 1) viol++;
    if (done && busy) viol++;
    if (error && !done) viol++;
    if ((buf_wr_en != '0 || ddr_req_valid) && !busy) viol++;
    if (pv && n_reset && (!ddr_req_valid || ddr_req_addr !== pa || ddr_req_len !== pl)) viol++;
    pv = ddr_req_valid && !ddr_req_ready;
    pa = ddr_req_addr;
    pl = ddr_req_len;
  end

  // DDR read responder: returns exactly the granted beats, with random gaps.
  initial begin
    ddr_rvalid = 1'b0; ddr_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!n_reset) begin
        sent = granted; ddr_rvalid = 1'b0;
      end else if (granted > sent && $urandom_range(0, 3) != 0) begin
        ddr_rdata = rand_beat(); ddr_rvalid = 1'b1;
        beat_q.push_back(ddr_rdata); sent++;
      end else if (spur) begin
        ddr_rdata = rand_beat(); ddr_rvalid = 1'b1;
      end else begin
        ddr_rvalid = 1'b0; ddr_rdata = '0;
      end
    end
  end

  initial begin
    ddr_req_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      ddr_req_ready = (ready_mode == 0) ? 1'b1 :
                      (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  task automatic do_cmd(input logic [BIW-1:0] bid, input logic [DAW-1:0] da,
                        input logic [BAW-1:0] ba, input logic [LW-1:0] len,
                        output int scyc, output bit timeout);
    int d0;
    d0 = done_cyc_q.size();
    @(posedge clk); #1;
    buffer_id = bid; ddr_base_addr = da; buf_base_addr = ba; total_len = len;
    start = 1'b1; scyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    timeout = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (done_cyc_q.size() > d0) begin timeout = 1'b0; break; end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    #12;
    vectors++;
    if ({busy, done, error, ddr_req_valid} !== 4'b0 || ddr_req_addr !== '0 || ddr_req_len !== '0 ||
        buf_wr_en !== '0 || buf_addr !== '0 || buf_data !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: busy=%b done=%b error=%b valid=%b wr_en=%b, all required 0",
               busy, done, error, ddr_req_valid, buf_wr_en);
    end
    @(negedge clk); n_reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // One well-formed load checked against the burst-split / contiguous-write model.
  task automatic test_load(input string name, input logic [BIW-1:0] bid, input logic [DAW-1:0] da,
                           input logic [BAW-1:0] ba, input logic [LW-1:0] len, input int mode);
    int w0, r0, b0, d0, scyc, k, rem, l, last;
    bit to;
    logic [DAW-1:0] a;
    logic [BAW-1:0] ea;
    logic [BC-1:0]  een;
    w0 = wr_addr_q.size(); r0 = rq_addr_q.size(); b0 = beat_q.size(); d0 = done_cyc_q.size();
    ready_mode = mode;
    do_cmd(bid, da, ba, len, scyc, to);
    ready_mode = 0;
    vectors++;
    if (to) begin miscompares++; $display("FAIL %s_timeout: no done within budget, done required", name); end
    rem = int'(len); a = da; k = 0;
    while (rem > 0) begin
      l = (rem > BM) ? BM : rem;
      vectors++;
      if (r0 + k >= rq_addr_q.size()) begin
        miscompares++; $display("FAIL %s_req%0d: missing, required addr=%h len=%0d", name, k, a, l);
      end else if (rq_addr_q[r0+k] !== a || int'(rq_len_q[r0+k]) != l) begin
        miscompares++;
        $display("FAIL %s_req%0d: addr=%h len=%0d, required addr=%h len=%0d",
                 name, k, rq_addr_q[r0+k], rq_len_q[r0+k], a, l);
      end
      a = a + DAW'(l * BPB); rem -= l; k++;
    end
    vectors++;
    if (rq_addr_q.size() - r0 != k) begin
      miscompares++; $display("FAIL %s_req_count: %0d, required %0d", name, rq_addr_q.size() - r0, k);
    end
    vectors++;
    if (wr_addr_q.size() - w0 != int'(len)) begin
      miscompares++; $display("FAIL %s_write_count: %0d, required %0d", name, wr_addr_q.size() - w0, len);
    end
    een = BC'(1) << bid;
    for (int i = 0; i < int'(len) && w0 + i < wr_addr_q.size() && b0 + i < beat_q.size(); i++) begin
      ea = ba + BAW'(i);
      vectors++;
      if (wr_addr_q[w0+i] !== ea || wr_en_q[w0+i] !== een || wr_data_q[w0+i] !== beat_q[b0+i]) begin
        miscompares++;
        $display("FAIL %s_write%0d: addr=%h en=%b data_ok=%b, required addr=%h en=%b",
                 name, i, wr_addr_q[w0+i], wr_en_q[w0+i], wr_data_q[w0+i] === beat_q[b0+i], ea, een);
      end
    end
    vectors++;
    if (done_cyc_q.size() - d0 != 1 || wr_addr_q.size() == w0) begin
      miscompares++; $display("FAIL %s_done_count: %0d, required 1", name, done_cyc_q.size() - d0);
    end else begin
      last = wr_cyc_q[wr_cyc_q.size()-1];
      vectors++;
      if (done_err_q[d0] !== 1'b0 || done_cyc_q[d0] != last + 1) begin
        miscompares++;
        $display("FAIL %s_done: error=%b cycle=%0d, required error=0 cycle=%0d",
                 name, done_err_q[d0], done_cyc_q[d0], last + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    int r0, w0, d0, n;
    logic [DAW-1:0] a0;
    logic [BW-1:0]  l0;
    bit seen;
    r0 = rq_addr_q.size(); w0 = wr_addr_q.size(); d0 = done_cyc_q.size();
    ready_mode = 2;
    @(posedge clk); #1;
    buffer_id = 3'd2; ddr_base_addr = 32'h8000_0040; buf_base_addr = 16'h0100; total_len = 16'd10;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk); seen = ddr_req_valid; end
    a0 = ddr_req_addr; l0 = ddr_req_len;
    vectors++;
    if (!seen || !busy || a0 !== 32'h8000_0040 || l0 !== 8'd10) begin
      miscompares++; $display("FAIL bp_first_req: valid=%b busy=%b addr=%h len=%0d, required 1 1 80000040 10",
                              seen, busy, a0, l0);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vectors++;
      if (!ddr_req_valid || ddr_req_addr !== a0 || ddr_req_len !== l0) begin
        miscompares++; $display("FAIL bp_hold%0d: valid=%b addr=%h len=%0d, required 1 %h %0d",
                                i, ddr_req_valid, ddr_req_addr, ddr_req_len, a0, l0);
      end
    end
    ready_mode = 0;
    n = 0;
    while (done_cyc_q.size() == d0 && n < 500) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    vectors++;
    if (rq_addr_q.size() - r0 != 1 || wr_addr_q.size() - w0 != 10 || done_cyc_q.size() - d0 != 1) begin
      miscompares++; $display("FAIL bp_result: reqs=%0d writes=%0d dones=%0d, required 1 10 1",
                              rq_addr_q.size() - r0, wr_addr_q.size() - w0, done_cyc_q.size() - d0);
    end
  endtask

  task automatic test_reject();
    logic [BIW-1:0] ids[3] = '{3'd5, 3'd0, 3'd4};
    logic [LW-1:0]  lens[3] = '{16'd7, 16'd0, 16'd3};
    int r0, w0, d0, scyc;
    bit to;
    for (int c = 0; c < 3; c++) begin
      r0 = rq_addr_q.size(); w0 = wr_addr_q.size(); d0 = done_cyc_q.size();
      do_cmd(ids[c], $urandom, 16'h0040, lens[c], scyc, to);
      vectors++;
      if (to || rq_addr_q.size() != r0 || wr_addr_q.size() != w0 || done_cyc_q.size() - d0 != 1) begin
        miscompares++; $display("FAIL reject%0d_traffic: timeout=%b reqs=%0d writes=%0d dones=%0d, required 0 0 0 1",
                                c, to, rq_addr_q.size() - r0, wr_addr_q.size() - w0, done_cyc_q.size() - d0);
      end else begin
        vectors++;
        if (done_err_q[d0] !== 1'b1 || done_cyc_q[d0] != scyc + 2) begin
          miscompares++; $display("FAIL reject%0d_done: error=%b cycle=%0d, required 1 %0d",
                                  c, done_err_q[d0], done_cyc_q[d0], scyc + 2);
        end
      end
    end
  endtask

  task automatic test_wrap_ignore();
    int w0, r0, d0, n;
    logic [BAW-1:0] exp_a[4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    w0 = wr_addr_q.size(); r0 = rq_addr_q.size(); d0 = done_cyc_q.size();
    ready_mode = 1;
    @(posedge clk); #1;
    buffer_id = 3'd3; ddr_base_addr = 32'h0000_2000; buf_base_addr = 16'hFFFE; total_len = 16'd4;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    buffer_id = 3'd0; ddr_base_addr = 32'h0000_9000; buf_base_addr = 16'h0010; total_len = 16'd9;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n = 0;
    while (done_cyc_q.size() == d0 && n < 500) begin @(negedge clk); n++; end
    ready_mode = 0;
    repeat (30) @(negedge clk);
    vectors++;
    if (wr_addr_q.size() - w0 != 4 || rq_addr_q.size() - r0 != 1 || done_cyc_q.size() - d0 != 1) begin
      miscompares++; $display("FAIL wrap_counts: writes=%0d reqs=%0d dones=%0d, required 4 1 1",
                              wr_addr_q.size() - w0, rq_addr_q.size() - r0, done_cyc_q.size() - d0);
    end
    for (int i = 0; i < 4 && w0 + i < wr_addr_q.size(); i++) begin
      vectors++;
      if (wr_addr_q[w0+i] !== exp_a[i] || wr_en_q[w0+i] !== 4'b1000) begin
        miscompares++; $display("FAIL wrap_write%0d: addr=%h en=%b, required %h 1000",
                                i, wr_addr_q[w0+i], wr_en_q[w0+i], exp_a[i]);
      end
    end
  endtask

  task automatic test_idle_rvalid();
    int w0, d0;
    w0 = wr_addr_q.size(); d0 = done_cyc_q.size();
    spur = 1'b1;
    repeat (6) @(negedge clk);
    spur = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (wr_addr_q.size() != w0 || done_cyc_q.size() != d0) begin
      miscompares++; $display("FAIL idle_rvalid: writes=%0d dones=%0d, required 0 0",
                              wr_addr_q.size() - w0, done_cyc_q.size() - d0);
    end
  endtask

  task automatic test_reset_mid();
    int w0, d0, n;
    w0 = wr_addr_q.size(); d0 = done_cyc_q.size();
    @(posedge clk); #1;
    buffer_id = 3'd1; ddr_base_addr = 32'h0004_0000; buf_base_addr = 16'h0200; total_len = 16'd100;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n = 0;
    while (wr_addr_q.size() < w0 + 10 && n < 500) begin @(negedge clk); n++; end
    #2 n_reset = 1'b0;
    #1;
    vectors++;
    if ({busy, done, error, ddr_req_valid} !== 4'b0 || buf_wr_en !== '0 || buf_addr !== '0 ||
        buf_data !== '0 || ddr_req_addr !== '0 || ddr_req_len !== '0) begin
      miscompares++; $display("FAIL mid_reset_outputs: busy=%b done=%b valid=%b wr_en=%b, all required 0",
                              busy, done, ddr_req_valid, buf_wr_en);
    end
    repeat (4) @(negedge clk);
    n_reset = 1'b1;
    repeat (10) @(negedge clk);
    vectors++;
    if (done_cyc_q.size() != d0) begin
      miscompares++; $display("FAIL mid_reset_no_done: dones=%0d, required 0", done_cyc_q.size() - d0);
    end
    test_load("after_reset", 3'd1, 32'h0004_0000, 16'h0200, 16'd20, 1);
  endtask

  initial begin
    test_reset();
    test_load("t1_single", 3'd1, 32'h0000_0100, 16'h0020, 16'd5, 0);
    test_load("t2_multi", 3'd2, 32'h0000_1000, 16'h0400, 16'd150, 1);
    test_backpressure();
    test_reject();
    test_wrap_ignore();
    test_idle_rvalid();
    test_reset_mid();
    test_load("ddr_wrap", 3'd0, 32'hFFFF_F800, 16'h1234, 16'd70, 1);
    for (int i = 0; i < 8; i++)
      test_load("random", BIW'($urandom_range(0, BC - 1)), $urandom, BAW'($urandom),
                LW'($urandom_range(1, 200)), int'($urandom_range(0, 1)));
    vectors++;
    if (viol != 0) begin
      miscompares++; $display("FAIL protocol_checks: %0d violations, required 0", viol);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
